seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the board's multiplexed 7-segment driver.
- Samples the scanned anode/segment lines, decodes each digit's active-low pattern back to BCD, and reassembles the 4-digit (16-bit) display word.
- Sits on the monitor/self-check path. Lets the displayed MM:SS, alarm, stopwatch and minigame values be compared against internal registers without a human reading the board.

---
 rtl/seg_scan_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Decodes the scanned display lines of the board's multiplexed 7-segment
//   driver back into the 4-digit BCD word shown on the display. It is used
//   on the monitor path so displayed values can be compared with registers.
//
//   Parameters
//     STABLE_CYCLES  : cycles {anode,seg} must hold before a digit is taken (2..255)
//     TIMEOUT_CYCLES : cycles without any capture before locked drops (<= 65535)
//
//   Ports
//     clk         : system clock
//     resetn      : asynchronous active-low reset
//     anode[3:0]  : scanned digit enables, active-low one-hot, bit3 = leftmost
//     seg[6:0]    : segment lines, active-low, bit0 = a ... bit6 = g
//     digits[15:0]: last complete frame, BCD nibbles, [15:12] = leftmost
//     frame_valid : one-cycle pulse in the cycle digits updates
//     locked      : high after the first frame, low after a capture timeout
//     blank_mask  : per position, last captured pattern was all segments off
//     err_mask    : sticky per position, an undecodable pattern was captured
//     all_on      : last frame showed all segments lit on every position
//     err_count   : saturating count of bad patterns and illegal-anode dwells
//
//   Handshake: frame_valid is a valid-only strobe with no ready; the
//   consumer must sample digits/all_on/blank_mask in the cycle it is high.
//
//   Optional build macro SEGDEC_ERR_CNT_EN enables the err_count counter;
//   without it err_count is tied to zero and nothing else changes.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  anode,
    input  logic [6:0]  seg,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic        locked,
    output logic [3:0]  blank_mask,
    output logic [3:0]  err_mask,
    output logic        all_on,
    output logic [7:0]  err_count
);

    localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_MAX = 16'(TIMEOUT_CYCLES);

    logic [3:0]  anode_s1, anode_s2;
    logic [6:0]  seg_s1, seg_s2;
    logic [10:0] prev_sample;
    logic [7:0]  stab_cnt;
    logic [15:0] to_cnt;
    logic [15:0] shadow;
    logic [3:0]  blank_sh;
    logic [3:0]  seen;
    logic [3:0]  seen_next;

    logic        changed;
    logic        off;
    logic        legal;
    logic        dwell_done;
    logic        capture;
    logic        frame_done;
    logic        timeout_hit;
    logic [3:0]  cap_mask;
    logic [3:0]  dec_nib;
    logic        dec_blank;
    logic        dec_bad;

    assign changed    = ({anode_s2, seg_s2} != prev_sample);
    assign off        = (anode_s2 == 4'b1111);
    assign cap_mask   = ~anode_s2;
    // Fires in the single cycle the counter steps onto STABLE_MAX; the
    // counter then saturates, so a dwell yields at most one event.
    assign dwell_done = !changed && !off && (stab_cnt == STABLE_MAX - 8'd1);
    assign capture    = dwell_done && legal;
    assign frame_done = (seen == 4'b1111);
    // A capture in the same cycle restarts the timeout instead.
    assign timeout_hit = !capture && (to_cnt == TIMEOUT_MAX - 16'd1);

    always_comb begin
        legal = 1'b0;
        case (anode_s2)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
    end

    // Decode on the lit-segment view {g..a}.
    always_comb begin
        dec_nib   = 4'hE;
        dec_blank = 1'b0;
        dec_bad   = 1'b0;
        case (~seg_s2)
            7'b0111111: dec_nib = 4'd0;
            7'b0000110: dec_nib = 4'd1;
            7'b1011011: dec_nib = 4'd2;
            7'b1001111: dec_nib = 4'd3;
            7'b1100110: dec_nib = 4'd4;
            7'b1101101: dec_nib = 4'd5;
            7'b1111101: dec_nib = 4'd6;
            7'b0000111: dec_nib = 4'd7;
            7'b1111111: dec_nib = 4'd8;
            7'b1101111: dec_nib = 4'd9;
            7'b0000000: begin
                dec_nib   = 4'hF;
                dec_blank = 1'b1;
            end
            default: dec_bad = 1'b1;
        endcase
    end

    // A completed or timed-out frame restarts collection, but a capture
    // landing in that same cycle is still recorded.
    always_comb begin
        seen_next = seen;
        if (frame_done || timeout_hit) begin
            seen_next = 4'b0000;
        end
        if (capture) begin
            seen_next = seen_next | cap_mask;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            anode_s1    <= 4'b1111;
            anode_s2    <= 4'b1111;
            seg_s1      <= 7'h7F;
            seg_s2      <= 7'h7F;
            prev_sample <= 11'h7FF;
            stab_cnt    <= 8'd0;
            to_cnt      <= 16'd0;
            shadow      <= 16'h0000;
            blank_sh    <= 4'b0000;
            seen        <= 4'b0000;
            digits      <= 16'h0000;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            blank_mask  <= 4'b0000;
            err_mask    <= 4'b0000;
            all_on      <= 1'b0;
        end else begin
            anode_s1    <= anode;
            anode_s2    <= anode_s1;
            seg_s1      <= seg;
            seg_s2      <= seg_s1;
            prev_sample <= {anode_s2, seg_s2};

            if (changed || off) begin
                stab_cnt <= 8'd0;
            end else if (stab_cnt != STABLE_MAX) begin
                stab_cnt <= stab_cnt + 8'd1;
            end

            if (capture) begin
                to_cnt <= 16'd0;
            end else if (to_cnt != TIMEOUT_MAX) begin
                to_cnt <= to_cnt + 16'd1;
            end

            for (int i = 0; i < 4; i++) begin
                if (capture && cap_mask[i]) begin
                    shadow[i*4 +: 4] <= dec_nib;
                    blank_sh[i]      <= dec_blank;
                    if (dec_bad) begin
                        err_mask[i] <= 1'b1;
                    end
                end
            end

            seen        <= seen_next;
            frame_valid <= frame_done;

            if (frame_done) begin
                digits     <= shadow;
                all_on     <= (shadow == 16'h8888);
                blank_mask <= blank_sh;
                locked     <= 1'b1;
            end else if (timeout_hit) begin
                locked     <= 1'b0;
            end
        end
    end

`ifdef SEGDEC_ERR_CNT_EN
    logic illegal_dwell;
    logic err_event;

    assign illegal_dwell = dwell_done && !legal;
    assign err_event     = (capture && dec_bad) || illegal_dwell;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_count <= 8'd0;
        end else if (err_event && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 100;

    // Lit-segment shapes {g..a} for BCD 0..9.
    localparam logic [6:0] SEG_LIT [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    logic        clk;
    logic        resetn;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic        frame_valid;
    logic        locked;
    logic [3:0]  blank_mask;
    logic [3:0]  err_mask;
    logic        all_on;
    logic [7:0]  err_count;

    seg_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .anode      (anode),
        .seg        (seg),
        .digits     (digits),
        .frame_valid(frame_valid),
        .locked     (locked),
        .blank_mask (blank_mask),
        .err_mask   (err_mask),
        .all_on     (all_on),
        .err_count  (err_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters and scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    int fv_count    = 0;
    int last_fv_cyc = 0;

    // {all_on, blank_mask, digits}
    logic [20:0] exp_q[$];

    // Reference model: what each position last showed, and which have been seen.
    logic [3:0] m_nib [4];
    logic [3:0] m_blank;
    logic [3:0] m_seen;
    logic [3:0] m_err_mask;
    int         m_err_cnt;
    int         m_frames;

    always @(negedge clk) begin
        if (resetn && frame_valid) begin
            logic [20:0] exp_v;
            fv_count++;
            last_fv_cyc = cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL frame_unexpected: got digits=%h, required no frame", digits);
            end else begin
                exp_v = exp_q.pop_front();
                if ({all_on, blank_mask, digits} !== exp_v) begin
                    miscompares++;
                    $display("FAIL frame_content: got all_on=%b blank=%b digits=%h, required all_on=%b blank=%b digits=%h",
                             all_on, blank_mask, digits, exp_v[20], exp_v[19:16], exp_v[15:0]);
                end
            end
        end
    end

    // ---------------- model helpers ----------------
    // Returns {bad, blank, nibble}.
    function automatic logic [5:0] ref_decode(input logic [6:0] sg);
        logic [6:0] lit;
        lit = ~sg;
        if (lit == 7'b0000000) return {2'b01, 4'hF};
        for (int d = 0; d < 10; d++) begin
            if (SEG_LIT[d] == lit) return {2'b00, 4'(d)};
        end
        return {2'b10, 4'hE};
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        return ~SEG_LIT[d];
    endfunction

    task automatic model_clear();
        m_seen     = 4'b0000;
        m_blank    = 4'b0000;
        m_err_mask = 4'b0000;
        m_err_cnt  = 0;
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int n);
        anode = an;
        seg   = sg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Show one digit at a legal position; the model predicts the frame first.
    task automatic scan_digit(input int pos, input logic [6:0] sg, input int gap, input int dwell);
        logic [5:0] r;
        logic [3:0] an;
        logic       all8;
        r = ref_decode(sg);
        m_nib[pos]   = r[3:0];
        m_blank[pos] = r[4];
        if (r[5]) begin
            m_err_mask[pos] = 1'b1;
`ifdef SEGDEC_ERR_CNT_EN
            if (m_err_cnt < 255) m_err_cnt++;
`endif
        end
        m_seen[pos] = 1'b1;
        if (m_seen == 4'b1111) begin
            all8 = 1'b1;
            for (int i = 0; i < 4; i++) if (m_nib[i] != 4'h8) all8 = 1'b0;
            exp_q.push_back({all8, m_blank, m_nib[3], m_nib[2], m_nib[1], m_nib[0]});
            m_seen = 4'b0000;
            m_frames++;
        end
        an = 4'b0001 << pos;
        if (gap > 0) drive(4'b1111, 7'h7F, gap);
        drive(~an, sg, dwell);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        anode  = 4'b1111;
        seg    = 7'h7F;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (digits !== 16'h0000) begin miscompares++; $display("FAIL reset_digits: got %h required 0000", digits); end
        vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fv: got %b required 0", frame_valid); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b required 0", locked); end
        vectors++; if (blank_mask !== 4'b0000) begin miscompares++; $display("FAIL reset_blank: got %b required 0000", blank_mask); end
        vectors++; if (err_mask !== 4'b0000) begin miscompares++; $display("FAIL reset_err_mask: got %b required 0000", err_mask); end
        vectors++; if (all_on !== 1'b0) begin miscompares++; $display("FAIL reset_all_on: got %b required 0", all_on); end
        vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL reset_err_count: got %0d required 0", err_count); end
        @(negedge clk);
        resetn = 1'b1;
        drive(4'b1111, 7'h7F, 3);
    endtask

    task automatic test_scan_basic();
        int fv0;
        fv0 = fv_count;
        scan_digit(0, seg_of(9), 2, 20);
        scan_digit(1, seg_of(5), 0, 20);
        scan_digit(2, seg_of(9), 0, 20);
        scan_digit(3, seg_of(5), 0, 20);
        drive(4'b1111, 7'h7F, 2);
        vectors++; if (fv_count - fv0 != 1) begin miscompares++; $display("FAIL basic_pulses: got %0d required 1", fv_count - fv0); end
        vectors++; if (digits !== 16'h5959) begin miscompares++; $display("FAIL basic_digits: got %h required 5959", digits); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL basic_locked: got %b required 1", locked); end
        vectors++; if (err_mask !== 4'b0000) begin miscompares++; $display("FAIL basic_err_mask: got %b required 0000", err_mask); end
    endtask

    task automatic test_unstable();
        int fv0;
        fv0 = fv_count;
        // Toggle every 2 cycles: never stable long enough to capture.
        for (int i = 0; i < 20; i++) begin
            drive(4'b1011, (i % 2 == 0) ? seg_of(1) : seg_of(7), 2);
        end
        scan_digit(2, seg_of(3), 0, 20);
        vectors++; if (fv_count != fv0) begin miscompares++; $display("FAIL unstable_no_frame: got %0d pulses required 0", fv_count - fv0); end
        scan_digit(0, seg_of(4), 2, 15);
        scan_digit(1, seg_of(2), 2, 15);
        vectors++; if (fv_count != fv0) begin miscompares++; $display("FAIL unstable_partial: got %0d pulses required 0", fv_count - fv0); end
        scan_digit(3, seg_of(8), 2, 15);
        drive(4'b1111, 7'h7F, 2);
        vectors++; if (digits !== 16'h8324) begin miscompares++; $display("FAIL unstable_digits: got %h required 8324", digits); end
        vectors++; if (fv_count - fv0 != 1) begin miscompares++; $display("FAIL unstable_pulses: got %0d required 1", fv_count - fv0); end
    endtask

    task automatic test_all_on();
        for (int p = 0; p < 4; p++) scan_digit(p, 7'b0000000, 2, 14);
        drive(4'b1111, 7'h7F, 2);
        vectors++; if (digits !== 16'h8888) begin miscompares++; $display("FAIL allon_digits: got %h required 8888", digits); end
        vectors++; if (all_on !== 1'b1) begin miscompares++; $display("FAIL allon_flag: got %b required 1", all_on); end
        scan_digit(3, seg_of(1), 2, 14);
        scan_digit(2, seg_of(2), 2, 14);
        scan_digit(1, seg_of(3), 2, 14);
        scan_digit(0, seg_of(4), 2, 14);
        drive(4'b1111, 7'h7F, 2);
        vectors++; if (digits !== 16'h1234) begin miscompares++; $display("FAIL allon_next_digits: got %h required 1234", digits); end
        vectors++; if (all_on !== 1'b0) begin miscompares++; $display("FAIL allon_next_flag: got %b required 0", all_on); end
    endtask

    task automatic test_invalid();
        scan_digit(0, seg_of(0), 2, 14);
        scan_digit(1, 7'b1110000, 2, 14);
        scan_digit(2, seg_of(0), 2, 14);
        scan_digit(3, seg_of(0), 2, 14);
        drive(4'b1111, 7'h7F, 2);
        vectors++; if (digits !== 16'h00E0) begin miscompares++; $display("FAIL invalid_digits: got %h required 00E0", digits); end
        vectors++; if (err_mask !== 4'b0010) begin miscompares++; $display("FAIL invalid_err_mask: got %b required 0010", err_mask); end
        vectors++; if (err_count !== 8'(m_err_cnt)) begin miscompares++; $display("FAIL invalid_err_count: got %0d required %0d", err_count, m_err_cnt); end
    endtask

    task automatic test_illegal_anode();
        int fv0;
        fv0 = fv_count;
        drive(4'b1111, 7'h7F, 2);
        drive(4'b1100, seg_of(1), 20);
        drive(4'b1111, 7'h7F, 2);
        drive(4'b0000, seg_of(6), 20);
        drive(4'b1111, 7'h7F, 2);
`ifdef SEGDEC_ERR_CNT_EN
        m_err_cnt = m_err_cnt + 2;
`endif
        vectors++; if (fv_count != fv0) begin miscompares++; $display("FAIL illegal_no_frame: got %0d pulses required 0", fv_count - fv0); end
        vectors++; if (err_count !== 8'(m_err_cnt)) begin miscompares++; $display("FAIL illegal_err_count: got %0d required %0d", err_count, m_err_cnt); end
        vectors++; if (err_mask !== m_err_mask) begin miscompares++; $display("FAIL illegal_err_mask: got %b required %b", err_mask, m_err_mask); end
    endtask

    task automatic test_random();
        int fv0;
        int f0;
        int p;
        int d;
        fv0 = fv_count;
        f0  = m_frames;
        while (m_frames - f0 < 25) begin
            p = $urandom_range(0, 3);
            d = $urandom_range(0, 10);
            scan_digit(p, (d == 10) ? 7'h7F : seg_of(d), $urandom_range(1, 3), $urandom_range(10, 20));
        end
        drive(4'b1111, 7'h7F, 4);
        vectors++; if (fv_count - fv0 != 25) begin miscompares++; $display("FAIL random_pulses: got %0d required 25", fv_count - fv0); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL random_pending: got %0d frames outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int fv0;
        int elapsed;
        scan_digit(0, seg_of(1), 2, 14);
        scan_digit(1, seg_of(2), 2, 14);
        scan_digit(2, seg_of(3), 2, 14);
        scan_digit(3, seg_of(4), 2, 14);
        fv0 = fv_count;
        anode = 4'b1111;
        seg   = 7'h7F;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!locked) break;
        end
        // frame_valid trails the last capture by one cycle.
        elapsed = cyc - last_fv_cyc;
        vectors++; if (elapsed != TIMEOUT - 1) begin miscompares++; $display("FAIL timeout_cycles: got %0d required %0d", elapsed, TIMEOUT - 1); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL timeout_locked: got %b required 0", locked); end
        vectors++; if (digits !== 16'h4321) begin miscompares++; $display("FAIL timeout_digits_hold: got %h required 4321", digits); end
        vectors++; if (fv_count != fv0) begin miscompares++; $display("FAIL timeout_no_frame: got %0d pulses required 0", fv_count - fv0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        int fv0;
        scan_digit(0, seg_of(3), 2, 14);
        scan_digit(1, seg_of(6), 2, 14);
        anode  = 4'b1111;
        seg    = 7'h7F;
        resetn = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(4'b1111, 7'h7F, 3);
        fv0 = fv_count;
        vectors++; if (err_mask !== 4'b0000) begin miscompares++; $display("FAIL midreset_err_mask: got %b required 0000", err_mask); end
        scan_digit(3, seg_of(0), 2, 14);
        scan_digit(2, seg_of(0), 2, 14);
        vectors++; if (fv_count != fv0) begin miscompares++; $display("FAIL midreset_stale_frame: got %0d pulses required 0", fv_count - fv0); end
        scan_digit(1, seg_of(0), 2, 14);
        scan_digit(0, seg_of(7), 2, 14);
        drive(4'b1111, 7'h7F, 2);
        vectors++; if (fv_count - fv0 != 1) begin miscompares++; $display("FAIL midreset_pulses: got %0d required 1", fv_count - fv0); end
        vectors++; if (digits !== 16'h0007) begin miscompares++; $display("FAIL midreset_digits: got %h required 0007", digits); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL midreset_locked: got %b required 1", locked); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        m_frames = 0;
        test_reset();
        test_scan_basic();
        test_unstable();
        test_all_on();
        test_invalid();
        test_illegal_anode();
        test_random();
        test_timeout();
        test_reset_mid_frame();
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL final_pending: got %0d frames outstanding required 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion required finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
